// File: rtl/zcws_pkg.sv
// zcws_pkg: shared types and helpers for zero_count_window_stats.
//   zcws_state_t      : window FSM state (ACCUM collects counts, HOLD presents a result)
//   ZCWS_MIN_INIT_BIT : fill bit for the running minimum at window start (all-ones)
//   zcws_clog2()      : ceiling log2 for elaboration-time width derivation
package zcws_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } zcws_state_t;

  localparam bit ZCWS_MIN_INIT_BIT = 1'b1;

  function automatic int unsigned zcws_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/zcws_win_ctr.sv
// zcws_win_ctr: position-in-window counter for zero_count_window_stats.
//   clk   : rising-edge clock
//   clear : synchronous clear to index 0
//   inc   : advance by one (wraps from WIN-1 to 0)
//   idx   : current index within the window
//   last  : idx == WIN-1 (the next accepted count completes the window)
module zcws_win_ctr
  import zcws_pkg::*;
#(
  parameter int unsigned WIN = 16,
  parameter int unsigned IW  = zcws_clog2(WIN)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  output logic [IW-1:0] idx,
  output logic          last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(WIN - 1);

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/zero_count_window_stats.sv
// zero_count_window_stats: collects WIN zero-count values per window and
// publishes sum / max / min plus a threshold alarm under valid/ready.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   cnt_in/cnt_valid/cnt_ready : incoming count handshake
//   thresh            : alarm threshold, sampled on the publishing cycle
//   win_sum/win_max/win_min    : published window statistics
//   win_valid/win_ready        : result handshake (held until consumed)
//   alarm             : win_sum > thresh for the published window
// Build option: ZCWS_STICKY_ALARM_EN makes alarm sticky (cleared only by rst);
// otherwise alarm clears when the result is consumed.
module zero_count_window_stats
  import zcws_pkg::*;
#(
  parameter int N   = 8,
  parameter int CW  = N - 4,
  parameter int WIN = 16,
  parameter int SW  = CW + int'(zcws_clog2(WIN))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt_in,
  input  logic          cnt_valid,
  output logic          cnt_ready,
  input  logic [SW-1:0] thresh,
  output logic [SW-1:0] win_sum,
  output logic [CW-1:0] win_max,
  output logic [CW-1:0] win_min,
  output logic          win_valid,
  input  logic          win_ready,
  output logic          alarm
);

  localparam int unsigned IW = zcws_clog2(WIN);
  localparam logic [CW-1:0] MIN_INIT = {CW{ZCWS_MIN_INIT_BIT}};

  zcws_state_t   state;
  logic [SW-1:0] acc;
  logic [CW-1:0] run_max;
  logic [CW-1:0] run_min;
  logic [IW-1:0] idx;
  logic          last;

  logic          accept;
  logic          publish;
  logic          consume;
  logic [SW-1:0] sum_next;
  logic [CW-1:0] max_next;
  logic [CW-1:0] min_next;
  logic          hit;

  // In HOLD the input side is gated by the consumer so a count arriving on
  // the consume cycle lands in the fresh window instead of being dropped.
  assign cnt_ready = (state == ACCUM) ? 1'b1 : win_ready;
  assign accept    = cnt_valid & cnt_ready;
  assign publish   = accept & last & (state == ACCUM);
  assign consume   = (state == HOLD) & win_ready;

  zcws_win_ctr #(
    .WIN (WIN),
    .IW  (IW)
  ) u_win_ctr (
    .clk   (clk),
    .clear (rst),
    .inc   (accept),
    .idx   (idx),
    .last  (last)
  );

  always_comb begin
    sum_next = acc + {{(SW - CW){1'b0}}, cnt_in};
    max_next = (cnt_in > run_max) ? cnt_in : run_max;
    min_next = (cnt_in < run_min) ? cnt_in : run_min;
    hit      = (sum_next > thresh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      run_max   <= '0;
      run_min   <= MIN_INIT;
      win_sum   <= '0;
      win_max   <= '0;
      win_min   <= '0;
      win_valid <= 1'b0;
      alarm     <= 1'b0;
    end else if (publish) begin
      win_sum   <= sum_next;
      win_max   <= max_next;
      win_min   <= min_next;
      win_valid <= 1'b1;
`ifdef ZCWS_STICKY_ALARM_EN
      alarm     <= alarm | hit;
`else
      alarm     <= hit;
`endif
      acc       <= '0;
      run_max   <= '0;
      run_min   <= MIN_INIT;
      state     <= HOLD;
    end else begin
      if (accept) begin
        acc     <= sum_next;
        run_max <= max_next;
        run_min <= min_next;
      end
      if (consume) begin
        win_valid <= 1'b0;
        state     <= ACCUM;
`ifndef ZCWS_STICKY_ALARM_EN
        alarm     <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_zero_count_window_stats.sv
module tb_zero_count_window_stats;

  localparam int N   = 8;
  localparam int CW  = 4;
  localparam int WIN = 4;
  localparam int SW  = 6;

  logic          clk;
  logic          rst;
  logic [CW-1:0] cnt_in;
  logic          cnt_valid;
  logic          cnt_ready;
  logic [SW-1:0] thresh;
  logic [SW-1:0] win_sum;
  logic [CW-1:0] win_max;
  logic [CW-1:0] win_min;
  logic          win_valid;
  logic          win_ready;
  logic          alarm;

  int errors = 0;
  int checks = 0;
  logic sticky = 1'b0;

  zero_count_window_stats #(
    .N   (N),
    .CW  (CW),
    .WIN (WIN),
    .SW  (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .thresh    (thresh),
    .win_sum   (win_sum),
    .win_max   (win_max),
    .win_min   (win_min),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c);
    cnt_valid = 1'b1;
    cnt_in    = c;
    step();
    cnt_valid = 1'b0;
  endtask

  // Expected alarm given whether the published window exceeded thresh.
  function automatic logic exp_alarm(input logic win_hit);
`ifdef ZCWS_STICKY_ALARM_EN
    return sticky;
`else
    return win_hit;
`endif
  endfunction

  task automatic chk_win(input string tag, input int s, input int mx, input int mn, input logic win_hit);
    sticky = sticky | win_hit;
    chk({tag, "_valid"}, 32'(win_valid), 32'd1);
    chk({tag, "_sum"},   32'(win_sum),   32'(s));
    chk({tag, "_max"},   32'(win_max),   32'(mx));
    chk({tag, "_min"},   32'(win_min),   32'(mn));
    chk({tag, "_alarm"}, 32'(alarm),     32'(exp_alarm(win_hit)));
  endtask

  initial begin
    rst = 1'b1; cnt_in = '0; cnt_valid = 1'b0; thresh = 6'd10; win_ready = 1'b1;
    step(); step();
    chk("rst_sum",   32'(win_sum),   32'd0);
    chk("rst_max",   32'(win_max),   32'd0);
    chk("rst_min",   32'(win_min),   32'd0);
    chk("rst_valid", 32'(win_valid), 32'd0);
    chk("rst_alarm", 32'(alarm),     32'd0);
    chk("rst_ready", 32'(cnt_ready), 32'd1);
    rst = 1'b0;
    step();

    // Basic window
    send(4'd1); send(4'd2); send(4'd3);
    chk("basic_nopub", 32'(win_valid), 32'd0);
    send(4'd4);
    chk_win("basic", 10, 4, 1, 1'b0);
    step();
    chk("basic_consumed", 32'(win_valid), 32'd0);

    // Alarm window, then a quiet window
    send(4'd8); send(4'd8); send(4'd0); send(4'd1);
    chk_win("alarm", 17, 8, 0, 1'b1);
    step();
    chk("alarm_consumed", 32'(win_valid), 32'd0);
    chk("alarm_after_consume", 32'(alarm), 32'(exp_alarm(1'b0)));
    send(4'd0); send(4'd0); send(4'd0); send(4'd0);
    chk_win("quiet", 0, 0, 0, 1'b0);
    step();

    // Back-pressure: held result, input blocked, then consume with a count
    win_ready = 1'b0;
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    chk_win("bp", 4, 1, 1, 1'b0);
    chk("bp_ready0", 32'(cnt_ready), 32'd0);
    cnt_valid = 1'b1; cnt_in = 4'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(win_valid), 32'd1);
      chk("bp_hold_sum",   32'(win_sum),   32'd4);
      chk("bp_hold_ready", 32'(cnt_ready), 32'd0);
    end
    cnt_in = 4'd7; win_ready = 1'b1;
    #1;
    chk("bp_passthru_ready", 32'(cnt_ready), 32'd1);
    step();
    cnt_valid = 1'b0;
    chk("bp_consumed", 32'(win_valid), 32'd0);
    send(4'd1); send(4'd1);
    chk("bp_nopub", 32'(win_valid), 32'd0);
    send(4'd1);
    chk_win("bp_next", 10, 7, 1, 1'b0);
    step();

    // Gappy input
    cnt_in = 4'd2;
    for (int i = 0; i < 10; i++) begin
      cnt_valid = ((i % 3) == 0);
      step();
      if (i < 9) chk("gap_nopub", 32'(win_valid), 32'd0);
    end
    cnt_valid = 1'b0;
    chk_win("gap", 8, 2, 2, 1'b0);
    step();
    chk("gap_single_pub", 32'(win_valid), 32'd0);

    // Reset mid-window
    send(4'd3); send(4'd3);
    rst = 1'b1;
    step();
    chk("mrst_sum",   32'(win_sum),   32'd0);
    chk("mrst_max",   32'(win_max),   32'd0);
    chk("mrst_min",   32'(win_min),   32'd0);
    chk("mrst_valid", 32'(win_valid), 32'd0);
    chk("mrst_alarm", 32'(alarm),     32'd0);
    chk("mrst_ready", 32'(cnt_ready), 32'd1);
    rst = 1'b0;
    sticky = 1'b0;
    send(4'd5); send(4'd5); send(4'd5);
    win_ready = 1'b0;
    send(4'd5);
    chk_win("mrst_win", 20, 5, 5, 1'b1);
    step();
    chk("hold_still_valid", 32'(win_valid), 32'd1);

    // Reset in HOLD
    rst = 1'b1;
    step();
    chk("hrst_valid", 32'(win_valid), 32'd0);
    chk("hrst_ready", 32'(cnt_ready), 32'd1);
    chk("hrst_alarm", 32'(alarm),     32'd0);
    chk("hrst_sum",   32'(win_sum),   32'd0);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
